// File: rtl/sys_bus_pkg.sv
// Shared types and constants for the 8085 system bus controller.
package sys_bus_pkg;

  typedef enum logic [1:0] {REG_NONE, REG_RAM, REG_ROM, REG_IO} region_e;
  typedef enum logic [1:0] {WS_IDLE, WS_ADDR, WS_WAIT, WS_DONE} wait_state_e;
  typedef enum logic [1:0] {ARB_CPU, ARB_REQ, ARB_DMA, ARB_REL} arb_state_e;

  localparam logic [7:0] RAM_PAGE = 8'h00;
  localparam logic [7:0] ROM_PAGE = 8'h01;

  // Only the high address byte matters for memory decode; I/O ignores it.
  function automatic region_e decode_region(input logic [7:0] page, input logic io);
    if (io)                   return REG_IO;
    else if (page == RAM_PAGE) return REG_RAM;
    else if (page == ROM_PAGE) return REG_ROM;
    else                       return REG_NONE;
  endfunction

endpackage

// File: rtl/bus_arbiter.sv
// HOLD/HLDA arbiter handing the bus between the CPU and one DMA master.
module bus_arbiter
  import sys_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       dma_req,
  input  logic       hlda,
  input  logic       cycle_idle,
  output logic       hold,
  output logic       dma_gnt,
  output arb_state_e state
);

  arb_state_e state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB_CPU;
    else     state <= state_nxt;
  end

  // A request is only honoured between bus cycles so a CPU cycle never gets cut.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_CPU: if (dma_req && cycle_idle) state_nxt = ARB_REQ;
      ARB_REQ: begin
        if (!dma_req)  state_nxt = ARB_REL;
        else if (hlda) state_nxt = ARB_DMA;
      end
      ARB_DMA: if (!dma_req) state_nxt = ARB_REL;
      ARB_REL: if (!hlda)    state_nxt = ARB_CPU;
      default:               state_nxt = ARB_CPU;
    endcase
  end

  assign hold    = (state == ARB_REQ) || (state == ARB_DMA);
  assign dma_gnt = (state == ARB_DMA);

endmodule

// File: rtl/sys_bus_ctrl.sv
// 8085 bus controller: address latch, chip-select decode, wait-state READY
// generation and CPU/DMA bus arbitration.
module sys_bus_ctrl
  import sys_bus_pkg::*;
#(
  parameter logic [3:0] RAM_WAIT = 4'd0,
  parameter logic [3:0] ROM_WAIT = 4'd1,
  parameter logic [3:0] IO_WAIT  = 4'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ale,
  input  logic [7:0]  ad,
  input  logic [7:0]  a_hi,
  input  logic        iomn,
  input  logic        rdn,
  input  logic        wrn,
  output logic [15:0] addr,
  output logic        ram_csn,
  output logic        rom_csn,
  output logic        io_csn,
  output logic        ready,
  output logic        bus_err,
  input  logic        dma_req,
  output logic        dma_gnt,
  output logic        hold,
  input  logic        hlda,
  output wait_state_e wait_state,
  output arb_state_e  arb_state
);

  wait_state_e wait_state_nxt;
  logic [3:0]  count, count_nxt;
  logic        iomn_q;
  logic        err_nxt;
  logic        strobe;
  logic        cs_en;
  logic        cycle_idle;
  region_e     in_region, cur_region;

  function automatic logic [3:0] wait_of(input region_e r);
    case (r)
      REG_RAM: return RAM_WAIT;
      REG_ROM: return ROM_WAIT;
      REG_IO:  return IO_WAIT;
      default: return 4'd0;
    endcase
  endfunction

  assign strobe     = !rdn || !wrn;
  assign in_region  = decode_region(a_hi, iomn);
  assign cur_region = decode_region(addr[15:8], iomn_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr       <= 16'h0000;
      iomn_q     <= 1'b0;
      wait_state <= WS_IDLE;
      count      <= 4'd0;
      bus_err    <= 1'b0;
    end else begin
      wait_state <= wait_state_nxt;
      count      <= count_nxt;
      bus_err    <= err_nxt;
      if (ale) begin
        addr   <= {a_hi, ad};
        iomn_q <= iomn;
      end
    end
  end

  // ALE in any state (re)starts a cycle; in ADDR/WAIT that is a tolerated protocol error.
  always_comb begin
    wait_state_nxt = wait_state;
    count_nxt      = count;
    err_nxt        = 1'b0;
    if (ale) begin
      wait_state_nxt = WS_ADDR;
      count_nxt      = wait_of(in_region);
    end else begin
      case (wait_state)
        WS_ADDR: begin
          if (strobe) begin
            err_nxt = (cur_region == REG_NONE);
            if (count == 4'd0) begin
              wait_state_nxt = WS_DONE;
            end else begin
              wait_state_nxt = WS_WAIT;
              count_nxt      = count - 4'd1;
            end
          end
        end
        WS_WAIT: begin
          if (count <= 4'd1) begin
            wait_state_nxt = WS_DONE;
            count_nxt      = 4'd0;
          end else begin
            count_nxt = count - 4'd1;
          end
        end
        WS_DONE: if (!strobe) wait_state_nxt = WS_IDLE;
        default: wait_state_nxt = WS_IDLE;
      endcase
    end
  end

  // Handshake: the master holds its strobe low and the transfer completes on the
  // first edge that sees ready=1 with the strobe low; ready=0 stretches the cycle.
  always_comb begin
    ready = 1'b1;
    if (wait_state == WS_ADDR || wait_state == WS_WAIT) ready = (count == 4'd0);
  end

  assign cs_en   = (wait_state != WS_IDLE);
  assign ram_csn = !(cs_en && cur_region == REG_RAM);
  assign rom_csn = !(cs_en && cur_region == REG_ROM);
  assign io_csn  = !(cs_en && cur_region == REG_IO);

  assign cycle_idle = (wait_state == WS_IDLE || wait_state == WS_DONE) && !ale;

  bus_arbiter u_arb (
    .clk        (clk),
    .rst        (rst),
    .dma_req    (dma_req),
    .hlda       (hlda),
    .cycle_idle (cycle_idle),
    .hold       (hold),
    .dma_gnt    (dma_gnt),
    .state      (arb_state)
  );

endmodule

// File: tb/tb_sys_bus_ctrl.sv
// Self-checking bench for sys_bus_ctrl: directed test-plan cycles plus random bus cycles.
module tb_sys_bus_ctrl;
  import sys_bus_pkg::*;

  localparam logic [3:0] RAM_W = 4'd0;
  localparam logic [3:0] ROM_W = 4'd1;
  localparam logic [3:0] IO_W  = 4'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ale = 1'b0;
  logic [7:0]  ad = 8'h00;
  logic [7:0]  a_hi = 8'h00;
  logic        iomn = 1'b0;
  logic        rdn = 1'b1;
  logic        wrn = 1'b1;
  logic        dma_req = 1'b0;
  logic        hlda = 1'b0;
  logic [15:0] addr;
  logic        ram_csn, rom_csn, io_csn, ready, bus_err, dma_gnt, hold;
  wait_state_e dbg_wait;
  arb_state_e  dbg_arb;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q[$];

  sys_bus_ctrl #(.RAM_WAIT(RAM_W), .ROM_WAIT(ROM_W), .IO_WAIT(IO_W)) dut (
    .clk(clk), .rst(rst), .ale(ale), .ad(ad), .a_hi(a_hi), .iomn(iomn),
    .rdn(rdn), .wrn(wrn), .addr(addr), .ram_csn(ram_csn), .rom_csn(rom_csn),
    .io_csn(io_csn), .ready(ready), .bus_err(bus_err), .dma_req(dma_req),
    .dma_gnt(dma_gnt), .hold(hold), .hlda(hlda), .wait_state(dbg_wait),
    .arb_state(dbg_arb)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: region rules and wait counts
  function automatic int model_wait(input logic [7:0] hi, input logic io);
    if (io)         return int'(IO_W);
    if (hi == 8'h00) return int'(RAM_W);
    if (hi == 8'h01) return int'(ROM_W);
    return 0;
  endfunction

  function automatic logic [2:0] model_cs(input logic [7:0] hi, input logic io);
    if (io)         return 3'b110;
    if (hi == 8'h00) return 3'b011;
    if (hi == 8'h01) return 3'b101;
    return 3'b111;
  endfunction

  // One bus cycle: ALE, g idle cycles, strobe held low until well past ready.
  // probe: -1 none, 0 raise dma_req with ALE, 1 raise dma_req after the ALE edge.
  task automatic run_cycle(input logic [7:0] hi, input logic [7:0] lo, input logic io,
                           input logic wr, input int g, input int extra, input int idle,
                           input int probe, input logic exp_hold, input logic exp_gnt);
    int          n, m, len;
    logic [2:0]  cs;
    logic        err;
    logic [15:0] exp_addr;
    n   = model_wait(hi, io);
    cs  = model_cs(hi, io);
    err = (cs == 3'b111);
    m   = g + 1;
    len = n + 2 + extra;
    exp_q.push_back({hi, lo});
    ale = 1'b1; a_hi = hi; ad = lo; iomn = io; rdn = 1'b1; wrn = 1'b1;
    if (probe == 0) dma_req = 1'b1;
    step();
    exp_addr = exp_q.pop_front();
    for (int t = 0; t < m + len; t++) begin
      check("addr", addr, exp_addr);
      check("cs", 16'({ram_csn, rom_csn, io_csn}), 16'(cs));
      check("ready", 16'(ready), 16'((n == 0) || (t >= m + n - 1)));
      check("bus_err", 16'(bus_err), 16'(err && (t == m)));
      if (probe >= 0) begin
        if (t <= m + n - 1) check("hold_defer", 16'(hold), 16'(0));
        if (t == m + len - 1) check("hold_after_cycle", 16'(hold), 16'(1));
        check("gnt_cpu_cycle", 16'(dma_gnt), 16'(0));
      end else begin
        check("hold", 16'(hold), 16'(exp_hold));
        check("dma_gnt", 16'(dma_gnt), 16'(exp_gnt));
      end
      if (t == 0) begin
        ale = 1'b0; a_hi = 8'($urandom); ad = 8'($urandom);
        if (probe == 1) dma_req = 1'b1;
      end
      if (t == m - 1) begin
        if (wr) wrn = 1'b0;
        else    rdn = 1'b0;
      end
      if (t == m + len - 1) begin
        rdn = 1'b1; wrn = 1'b1;
      end else begin
        step();
      end
    end
    for (int i = 0; i < idle; i++) begin
      step();
      check("cs_idle", 16'({ram_csn, rom_csn, io_csn}), 16'(3'b111));
      check("ready_idle", 16'(ready), 16'(1));
      check("bus_err_idle", 16'(bus_err), 16'(0));
      check("hold_idle", 16'(hold), 16'(exp_hold));
      check("gnt_idle", 16'(dma_gnt), 16'(exp_gnt));
    end
  endtask

  task automatic rand_cycle(input logic exp_hold, input logic exp_gnt, input int min_idle);
    logic [7:0] hi;
    logic       io;
    int         r;
    r  = $urandom_range(0, 3);
    io = (r == 3);
    case (r)
      0:       hi = 8'h00;
      1:       hi = 8'h01;
      2:       hi = 8'($urandom_range(2, 255));
      default: hi = 8'($urandom);
    endcase
    run_cycle(hi, 8'($urandom), io, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
              $urandom_range(0, 2), $urandom_range(min_idle, 2), -1, exp_hold, exp_gnt);
  endtask

  // Finish a DMA request already pending (hold=1): grant, DMA traffic, release.
  task automatic dma_session(input int n_rand);
    hlda = 1'b1;
    step();
    check("gnt_after_hlda", 16'(dma_gnt), 16'(1));
    check("hold_in_dma", 16'(hold), 16'(1));
    run_cycle(8'h00, 8'h10, 1'b0, 1'b1, 0, 0, 1, -1, 1'b1, 1'b1);
    for (int i = 0; i < n_rand; i++) rand_cycle(1'b1, 1'b1, 1);
    dma_req = 1'b0;
    step();
    check("hold_release", 16'(hold), 16'(0));
    check("gnt_release", 16'(dma_gnt), 16'(0));
    step();
    check("hold_rel_wait", 16'(hold), 16'(0));
    hlda = 1'b0;
    step();
    check("arb_back_cpu", 16'(dbg_arb), 16'(ARB_CPU));
    dma_req = 1'b1;
    step();
    check("hold_latency", 16'(hold), 16'(1));
    dma_req = 1'b0;
    step();
    check("hold_req_drop", 16'(hold), 16'(0));
    check("gnt_req_drop", 16'(dma_gnt), 16'(0));
    step();
    check("arb_cpu_after_drop", 16'(dbg_arb), 16'(ARB_CPU));
  endtask

  initial begin
    step();
    step();
    check("rst_addr", addr, 16'h0000);
    check("rst_cs", 16'({ram_csn, rom_csn, io_csn}), 16'(3'b111));
    check("rst_ready", 16'(ready), 16'(1));
    check("rst_bus_err", 16'(bus_err), 16'(0));
    check("rst_hold", 16'(hold), 16'(0));
    check("rst_gnt", 16'(dma_gnt), 16'(0));
    check("rst_wait_state", 16'(dbg_wait), 16'(WS_IDLE));
    rst = 1'b0;
    step();

    // directed test-plan cycles
    run_cycle(8'h00, 8'h42, 1'b0, 1'b0, 0, 1, 1, -1, 1'b0, 1'b0);
    run_cycle(8'h01, 8'h05, 1'b0, 1'b0, 0, 0, 1, -1, 1'b0, 1'b0);
    run_cycle(8'h10, 8'h10, 1'b1, 1'b1, 0, 0, 1, -1, 1'b0, 1'b0);
    run_cycle(8'h30, 8'h00, 1'b0, 1'b0, 0, 0, 1, -1, 1'b0, 1'b0);
    run_cycle(8'h00, 8'h80, 1'b0, 1'b1, 1, 0, 0, -1, 1'b0, 1'b0);
    run_cycle(8'h01, 8'hff, 1'b0, 1'b0, 2, 1, 1, -1, 1'b0, 1'b0);

    // random CPU traffic
    for (int i = 0; i < 30; i++) rand_cycle(1'b0, 1'b0, 0);
    step();

    // DMA request during a ROM wait, then the full handshake
    run_cycle(8'h01, 8'h20, 1'b0, 1'b0, 2, 0, 1, 1, 1'b1, 1'b0);
    dma_session(3);

    // DMA request on the same edge as ALE of an I/O write
    run_cycle(8'h44, 8'h44, 1'b1, 1'b1, 0, 1, 1, 0, 1'b1, 1'b0);
    dma_session(2);

    // reset in the middle of a DMA-driven I/O wait
    dma_req = 1'b1;
    step();
    hlda = 1'b1;
    step();
    ale = 1'b1; a_hi = 8'h10; ad = 8'h10; iomn = 1'b1;
    step();
    ale = 1'b0; wrn = 1'b0;
    step();
    check("ready_before_rst", 16'(ready), 16'(0));
    check("hold_before_rst", 16'(hold), 16'(1));
    #2 rst = 1'b1;
    #1;
    check("async_rst_ready", 16'(ready), 16'(1));
    check("async_rst_cs", 16'({ram_csn, rom_csn, io_csn}), 16'(3'b111));
    check("async_rst_addr", addr, 16'h0000);
    check("async_rst_hold", 16'(hold), 16'(0));
    check("async_rst_gnt", 16'(dma_gnt), 16'(0));
    wrn = 1'b1; dma_req = 1'b0; hlda = 1'b0; iomn = 1'b0;
    step();
    rst = 1'b0;
    run_cycle(8'h00, 8'h42, 1'b0, 1'b0, 0, 0, 1, -1, 1'b0, 1'b0);
    run_cycle(8'h01, 8'h05, 1'b0, 1'b1, 1, 0, 1, -1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
